fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit, 16-deep async FIFO among NREQ requesters in the wclk domain.
- Grants one requester at a time, round-robin, for a burst of up to MAXBURST beats.
- Passes the granted requester's data to the FIFO write port and gates the FIFO write strobe with the FIFO full flag.
- Sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; must equal the FIFO data width
- MAXBURST, 4, maximum beats per grant (1..16)
- IDLE_TO, 8, cycles a granted requester may hold req_valid low before its grant is revoked (1..255)

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW]
- req_last  in  NREQ  marks the final beat of a requester's packet
- req_ready  out  NREQ  per-requester accept; a beat transfers when valid & ready
- fifo_full  in  1  FIFO registered full flag
- fifo_winc  out  1  FIFO write increment
- fifo_wdata  out  DW  FIFO write data
- grant_id  out  3  index of the current grantee; valid only while busy=1
- busy  out  1  1 while in state GRANT

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0; to_cnt=0.
  - busy=0; req_ready=0; fifo_winc=0; fifo_wdata=0.
  - A burst in flight is abandoned; no partial write is issued after reset asserts.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, select the first requester at or after rr_ptr, searching upward with wrap modulo NREQ.
  - Register the selection in grant_id; next state is GRANT.
  - Arbitration latency is 1 cycle from req_valid to req_ready.
  - If no req_valid is high, stay in IDLE.
- GRANT, datapath (combinational, zero latency):
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - fifo_winc = req_valid[grant_id] & !fifo_full.
  - fifo_wdata = req_data of grant_id. When no beat is transferring, fifo_wdata is don't-care but must not be X.
- GRANT, on each accepted beat:
  - beat_cnt increments.
  - If req_last is high or beat_cnt+1 == MAXBURST: next state IDLE, rr_ptr = grant_id+1 (mod NREQ), beat_cnt=0.
- Idle timeout:
  - In GRANT, to_cnt increments on each cycle with req_valid[grant_id]=0 and clears on each cycle with it high.
  - When to_cnt reaches IDLE_TO: next state IDLE, rr_ptr advances as above.
- fifo_full high:
  - No transfer; beat_cnt holds; to_cnt is unaffected.
  - The grant is held indefinitely while full; there is no full timeout.
- Every burst end passes through one IDLE cycle, so the maximum sustained rate is MAXBURST beats per MAXBURST+1 cycles.
- No duplication or loss:
  - A beat is counted and written exactly once, in the cycle valid & ready.
  - The requester must hold req_data and req_last stable while valid & !ready.
- A requester that deasserts req_valid mid-packet keeps its grant until IDLE_TO expires. Its packet may then be interleaved with other requesters' packets; packet reassembly is the consumer's responsibility.

Optional Feature:
- Macro WR_ARB_PRIO_EN.
- Defined:
  - Requester 0 has strict priority in IDLE: if req_valid[0]=1 it is granted regardless of rr_ptr.
  - A grant to requester 0 does not modify rr_ptr; all other requesters stay round-robin.
  - An active burst is never preempted.
- Not defined: pure round-robin as described in Behaviour.

Test Plan:
- Reset then single requester: req1 sends 3 beats 0x11,0x22,0x33 with last on beat 3.
  - Expect ready on cycle 2; fifo_winc high for 3 consecutive cycles with that data.
  - Then busy=0 for 1 cycle and rr_ptr=2.
- All 4 requesters continuously valid, no last, MAXBURST=4.
  - Grant order 0,1,2,3,0; exactly 4 beats per grant.
  - 16 writes in 20 cycles.
- fifo_full asserted for 5 cycles mid-burst after beat 2.
  - fifo_winc=0 and req_ready=0 for those 5 cycles; beat_cnt holds at 2.
  - After full drops, 2 more beats, then release.
- req2 granted, then req_valid[2] drops for 8 cycles with IDLE_TO=8.
  - Grant revoked on cycle 8; busy=0 next cycle.
  - A pending req3 is granted on the following cycle.
- wrst_n pulsed low mid-burst (after beat 1 of 4).
  - fifo_winc, req_ready and busy drop asynchronously to 0 the same cycle.
  - After release, arbitration restarts at requester 0.
- WR_ARB_PRIO_EN defined, req0 and req3 both valid, rr_ptr=3.
  - Req0 granted first, req3 next; rr_ptr remains 3 after the req0 burst.
  - Without the macro, req3 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between NREQ requesters, the write arbiter and the FIFO write port.
// The arbiter connects through the slave modport; the requesters/FIFO side uses master.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_winc;
  logic [DW-1:0]      fifo_wdata;
  logic [2:0]         grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_winc, fifo_wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_winc, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async-FIFO write port among NREQ
// requesters in the wclk domain. A grantee keeps the port for up to MAXBURST
// beats, until its last beat, or until it idles for IDLE_TO cycles.
// Optional macro WR_ARB_PRIO_EN: requester 0 wins every arbitration it enters
// and its grants leave the round-robin pointer untouched.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = 4,
  parameter int IDLE_TO  = 8
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int             BCW       = $clog2(MAXBURST + 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAXBURST - 1);
  localparam logic [7:0]     TO_LAST   = 8'(IDLE_TO - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_r;
  logic [2:0]        rr_ptr_r;
  logic [2:0]        grant_id_r;
  logic [BCW-1:0]    beat_cnt_r;
  logic [7:0]        to_cnt_r;

  logic [2*NREQ-1:0] rot_s;
  logic [3:0]        sum_s;
  logic [2:0]        pick_s;
  logic              pick_vld_s;
  logic              gvalid_s;
  logic              glast_s;
  logic [DW-1:0]     gdata_s;
  logic              accept_s;
  logic [2:0]        next_ptr_s;

  // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot_s      = {bus.req_valid, bus.req_valid} >> rr_ptr_r;
    sum_s      = 4'd0;
    pick_s     = 3'd0;
    pick_vld_s = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      sum_s      = {1'b0, rr_ptr_r} + 4'(j);
      pick_s     = rot_s[j] ? ((sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0]) : pick_s;
      pick_vld_s = pick_vld_s | rot_s[j];
    end
`ifdef WR_ARB_PRIO_EN
    pick_s = bus.req_valid[0] ? 3'd0 : pick_s;
`endif
  end

  // Mux the current grantee's valid/last/data and work out the post-burst pointer.
  always_comb begin
    gvalid_s = 1'b0;
    glast_s  = 1'b0;
    gdata_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gvalid_s = (grant_id_r == 3'(i)) ? bus.req_valid[i]           : gvalid_s;
      glast_s  = (grant_id_r == 3'(i)) ? bus.req_last[i]            : glast_s;
      gdata_s  = (grant_id_r == 3'(i)) ? bus.req_data[i*DW +: DW]   : gdata_s;
    end
    accept_s   = (state_r == ST_GRANT) && gvalid_s && !bus.fifo_full;
    next_ptr_s = (grant_id_r == 3'(NREQ - 1)) ? 3'd0 : grant_id_r + 3'd1;
`ifdef WR_ARB_PRIO_EN
    // Requester 0 is served outside the rotation, so its bursts leave the pointer alone.
    next_ptr_s = (grant_id_r == 3'd0) ? rr_ptr_r : next_ptr_s;
`endif
  end

  // Zero-latency write datapath; everything is forced low outside GRANT, including during reset.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_winc  = 1'b0;
    bus.fifo_wdata = '0;
    if (state_r == ST_GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        bus.req_ready[i] = (grant_id_r == 3'(i)) && !bus.fifo_full;
      end
      bus.fifo_winc  = gvalid_s && !bus.fifo_full;
      bus.fifo_wdata = gdata_s;
    end else begin
      bus.fifo_winc  = 1'b0;
    end
  end

  assign bus.busy     = (state_r == ST_GRANT);
  assign bus.grant_id = grant_id_r;

  // Arbitration FSM: grant in IDLE, count beats and idle cycles in GRANT.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= 3'd0;
      grant_id_r <= 3'd0;
      beat_cnt_r <= '0;
      to_cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          beat_cnt_r <= '0;
          to_cnt_r   <= 8'd0;
          if (pick_vld_s) begin
            grant_id_r <= pick_s;
            state_r    <= ST_GRANT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (accept_s) begin
            to_cnt_r <= 8'd0;
            if (glast_s || (beat_cnt_r == BEAT_LAST)) begin
              state_r    <= ST_IDLE;
              beat_cnt_r <= '0;
              rr_ptr_r   <= next_ptr_s;
            end else begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
          end else if (!gvalid_s) begin
            // Idle cycles count whether or not the FIFO is full.
            if (to_cnt_r == TO_LAST) begin
              state_r    <= ST_IDLE;
              beat_cnt_r <= '0;
              to_cnt_r   <= 8'd0;
              rr_ptr_r   <= next_ptr_s;
            end else begin
              to_cnt_r   <= to_cnt_r + 8'd1;
            end
          end else begin
            // Valid but blocked by full: grant held, beat count frozen.
            to_cnt_r <= 8'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized
// run, all cross-checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, MAXBURST = 4, IDLE_TO = 8;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST), .IDLE_TO(IDLE_TO)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .bus(bus)
  );

  always #5 wclk = ~wclk;

  // Reference model: who holds the port, beats sent, idle run length, rotation pointer.
  bit              m_busy;
  int              m_g, m_beats, m_idle, m_ptr, wr_cnt, pick, idx;
  bit              end_b, e_winc, e_valid, e_last;
  logic [NREQ-1:0] e_ready, m_acc;
  logic [DW-1:0]   e_data;

  always @(negedge wclk) begin : monitor
    if (!wrst_n) begin
      m_busy = 1'b0; m_g = 0; m_beats = 0; m_idle = 0; m_ptr = 0; m_acc = '0;
      total++;
      if (bus.busy !== 1'b0 || bus.fifo_winc !== 1'b0 || bus.req_ready !== '0 || bus.fifo_wdata !== '0) begin
        bad++;
        $display("FAIL mon_reset busy=%b winc=%b ready=%b wdata=%h, required all zero", bus.busy, bus.fifo_winc, bus.req_ready, bus.fifo_wdata);
      end
    end else begin
      e_ready = '0; e_winc = 1'b0; e_data = '0; e_valid = 1'b0; e_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (m_busy && i == m_g) begin
          e_ready[i] = !bus.fifo_full;
          e_valid    = bus.req_valid[i];
          e_last     = bus.req_last[i];
          e_winc     = bus.req_valid[i] && !bus.fifo_full;
          e_data     = bus.req_data[i*DW +: DW];
        end
      end
      total++;
      if (bus.busy !== m_busy) begin bad++; $display("FAIL mon_busy got=%b want=%b t=%0t", bus.busy, m_busy, $time); end
      if (m_busy) begin
        total++;
        if (bus.grant_id !== 3'(m_g)) begin bad++; $display("FAIL mon_grant got=%0d want=%0d t=%0t", bus.grant_id, m_g, $time); end
      end
      total++;
      if (bus.req_ready !== e_ready) begin bad++; $display("FAIL mon_ready got=%b want=%b t=%0t", bus.req_ready, e_ready, $time); end
      total++;
      if (bus.fifo_winc !== e_winc) begin bad++; $display("FAIL mon_winc got=%b want=%b t=%0t", bus.fifo_winc, e_winc, $time); end
      if (e_winc) begin
        total++;
        if (bus.fifo_wdata !== e_data) begin bad++; $display("FAIL mon_wdata got=%h want=%h t=%0t", bus.fifo_wdata, e_data, $time); end
      end
      total++;
      if ($isunknown(bus.fifo_wdata)) begin bad++; $display("FAIL mon_wdata_x got=%h want=known t=%0t", bus.fifo_wdata, $time); end
      m_acc = '0;
      if (e_winc) begin
        for (int i = 0; i < NREQ; i++) if (i == m_g) m_acc[i] = 1'b1;
        wr_cnt++;
      end
      // Advance the model to the state it holds after the coming clock edge.
      if (!m_busy) begin
        pick = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % NREQ;
          for (int i = 0; i < NREQ; i++) if (i == idx && bus.req_valid[i]) pick = idx;
        end
`ifdef WR_ARB_PRIO_EN
        if (bus.req_valid[0]) pick = 0;
`endif
        if (pick >= 0) begin m_busy = 1'b1; m_g = pick; m_beats = 0; m_idle = 0; end
      end else begin
        end_b = 1'b0;
        if (e_winc) begin
          m_beats++; m_idle = 0;
          if (e_last || m_beats == MAXBURST) end_b = 1'b1;
        end else if (!e_valid) begin
          m_idle++;
          if (m_idle == IDLE_TO) end_b = 1'b1;
        end else begin
          m_idle = 0;
        end
        if (end_b) begin
          m_busy = 1'b0; m_beats = 0; m_idle = 0;
`ifdef WR_ARB_PRIO_EN
          if (m_g != 0)
`endif
          m_ptr = (m_g + 1) % NREQ;
        end
      end
    end
  end

  task automatic smp(); @(negedge wclk); endtask
  task automatic nxt(); @(posedge wclk); #1; endtask

  task automatic do_reset();
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    wrst_n = 1'b0;
    smp(); nxt();
    wrst_n = 1'b1;
  endtask

  // Release requesters whose beat was taken at the last edge.
  task automatic drop_accepted();
    for (int i = 0; i < NREQ; i++) if (m_acc[i]) begin bus.req_valid[i] = 1'b0; bus.req_last[i] = 1'b0; end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    wrst_n = 1'b0; #1;
    total++;
    if (bus.busy !== 1'b0 || bus.fifo_winc !== 1'b0 || bus.req_ready !== 4'b0000 || bus.fifo_wdata !== 8'h00) begin
      bad++; $display("FAIL reset_outputs busy=%b winc=%b ready=%b wdata=%h, required zeros", bus.busy, bus.fifo_winc, bus.req_ready, bus.fifo_wdata);
    end
    smp(); nxt(); wrst_n = 1'b1;
    smp();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b want=0", bus.busy); end
    nxt();
  endtask

  task automatic test_single();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    bus.req_valid[1] = 1'b1; bus.req_data[15:8] = 8'h11; bus.req_last[1] = 1'b0;
    smp();
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_latency ready=%b want=0000", bus.req_ready); end
    nxt();
    for (int b = 0; b < 3; b++) begin
      smp();
      total++;
      if (bus.fifo_winc !== 1'b1 || bus.req_ready !== 4'b0010 || bus.fifo_wdata !== exp_d[b]) begin
        bad++; $display("FAIL single_beat%0d winc=%b ready=%b data=%h want 1/0010/%h", b, bus.fifo_winc, bus.req_ready, bus.fifo_wdata, exp_d[b]);
      end
      nxt();
      if (b < 2) begin bus.req_data[15:8] = exp_d[b+1]; bus.req_last[1] = (b == 1); end
      else begin bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0; end
    end
    smp();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_release busy=%b want=0", bus.busy); end
    nxt();
    bus.req_valid[0] = 1'b1; bus.req_last[0] = 1'b1; bus.req_data[7:0] = 8'hA0;
    bus.req_valid[2] = 1'b1; bus.req_last[2] = 1'b1; bus.req_data[23:16] = 8'hA2;
    smp(); nxt(); smp();
    total++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 3'd2 || bus.fifo_wdata !== 8'hA2) begin
      bad++; $display("FAIL single_rrptr busy=%b grant=%0d data=%h want 1/2/a2", bus.busy, bus.grant_id, bus.fifo_wdata);
    end
    for (int c = 0; c < 6; c++) begin nxt(); drop_accepted(); smp(); end
    nxt();
  endtask

  task automatic test_rr_all();
    int wr;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin bus.req_valid[i] = 1'b1; bus.req_data[i*DW +: DW] = 8'(i * 16); end
    wr = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (bus.fifo_winc === 1'b1) begin
        total++;
        if (bus.grant_id !== 3'(wr / 4)) begin bad++; $display("FAIL rr_order write%0d grant=%0d want=%0d", wr, bus.grant_id, wr / 4); end
        wr++;
      end
      nxt();
      for (int i = 0; i < NREQ; i++) if (m_acc[i]) bus.req_data[i*DW +: DW] = bus.req_data[i*DW +: DW] + 8'd1;
    end
    total++;
    if (wr != 16) begin bad++; $display("FAIL rr_rate writes=%0d want=16 in 20 cycles", wr); end
    smp();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_gap busy=%b want=0", bus.busy); end
    nxt(); smp();
    total++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 3'd0) begin bad++; $display("FAIL rr_wrap busy=%b grant=%0d want 1/0", bus.busy, bus.grant_id); end
    nxt();
  endtask

  task automatic test_full();
    do_reset();
    bus.req_valid[0] = 1'b1; bus.req_data[7:0] = 8'h50;
    smp(); nxt();
    for (int b = 0; b < 2; b++) begin
      smp();
      total++;
      if (bus.fifo_winc !== 1'b1) begin bad++; $display("FAIL full_pre%0d winc=%b want=1", b, bus.fifo_winc); end
      nxt(); bus.req_data[7:0] = bus.req_data[7:0] + 8'd1;
    end
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp();
      total++;
      if (bus.fifo_winc !== 1'b0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL full_hold%0d winc=%b ready=%b busy=%b want 0/0000/1", c, bus.fifo_winc, bus.req_ready, bus.busy);
      end
      nxt();
    end
    bus.fifo_full = 1'b0;
    for (int b = 0; b < 2; b++) begin
      smp();
      total++;
      if (bus.fifo_winc !== 1'b1 || bus.fifo_wdata !== 8'(8'h52 + b)) begin
        bad++; $display("FAIL full_post%0d winc=%b data=%h want 1/%h", b, bus.fifo_winc, bus.fifo_wdata, 8'(8'h52 + b));
      end
      nxt(); bus.req_data[7:0] = bus.req_data[7:0] + 8'd1;
    end
    smp();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL full_release busy=%b want=0", bus.busy); end
    nxt(); bus.req_valid[0] = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req_valid[2] = 1'b1; bus.req_data[23:16] = 8'h2A;
    smp(); nxt(); smp();
    total++;
    if (bus.fifo_winc !== 1'b1 || bus.grant_id !== 3'd2) begin bad++; $display("FAIL to_grant winc=%b grant=%0d want 1/2", bus.fifo_winc, bus.grant_id); end
    nxt();
    bus.req_valid[2] = 1'b0;
    bus.req_valid[3] = 1'b1; bus.req_last[3] = 1'b1; bus.req_data[31:24] = 8'h3B;
    for (int k = 1; k <= IDLE_TO; k++) begin
      smp();
      total++;
      if (bus.busy !== 1'b1 || bus.grant_id !== 3'd2 || bus.fifo_winc !== 1'b0) begin
        bad++; $display("FAIL to_held%0d busy=%b grant=%0d winc=%b want 1/2/0", k, bus.busy, bus.grant_id, bus.fifo_winc);
      end
      nxt();
    end
    smp();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_revoke busy=%b want=0", bus.busy); end
    nxt(); smp();
    total++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 3'd3 || bus.fifo_winc !== 1'b1 || bus.fifo_wdata !== 8'h3B) begin
      bad++; $display("FAIL to_next busy=%b grant=%0d winc=%b data=%h want 1/3/1/3b", bus.busy, bus.grant_id, bus.fifo_winc, bus.fifo_wdata);
    end
    nxt(); drop_accepted();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid[1] = 1'b1; bus.req_data[15:8] = 8'h61;
    smp(); nxt(); smp(); nxt();
    bus.req_data[15:8] = 8'h62;
    #2;
    total++;
    if (bus.fifo_winc !== 1'b1) begin bad++; $display("FAIL rstmid_pre winc=%b want=1", bus.fifo_winc); end
    wrst_n = 1'b0; #1;
    total++;
    if (bus.fifo_winc !== 1'b0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_async winc=%b ready=%b busy=%b want 0/0000/0", bus.fifo_winc, bus.req_ready, bus.busy);
    end
    smp(); nxt();
    wrst_n = 1'b1;
    bus.req_valid = 4'b1001; bus.req_last = 4'b1001; bus.req_data = 32'hD3_00_00_D0;
    smp(); nxt(); smp();
    total++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 3'd0) begin bad++; $display("FAIL rstmid_restart busy=%b grant=%0d want 1/0", bus.busy, bus.grant_id); end
    for (int c = 0; c < 4; c++) begin nxt(); drop_accepted(); smp(); end
    nxt();
  endtask

  task automatic test_prio();
    int got [$];
    int exp_o [3];
`ifdef WR_ARB_PRIO_EN
    exp_o[0] = 0; exp_o[1] = 3; exp_o[2] = 1;
`else
    exp_o[0] = 3; exp_o[1] = 0; exp_o[2] = 1;
`endif
    do_reset();
    bus.req_valid[2] = 1'b1; bus.req_last[2] = 1'b1; bus.req_data[23:16] = 8'h72;
    smp(); nxt(); smp(); nxt();
    bus.req_valid = 4'b1011; bus.req_last = 4'b1011; bus.req_data = 32'h83_00_81_80;
    for (int c = 0; c < 12; c++) begin
      smp();
      if (bus.fifo_winc === 1'b1) got.push_back(int'(bus.grant_id));
      nxt(); drop_accepted();
    end
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL prio_count writes=%0d want=3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) begin
        total++;
        if (got[k] != exp_o[k]) begin bad++; $display("FAIL prio_order%0d grant=%0d want=%0d", k, got[k], exp_o[k]); end
      end
    end
  endtask

  task automatic test_random();
    int prob, w0;
    do_reset();
    w0 = wr_cnt;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      prob = (c < 1000) ? 70 : ((c < 2000) ? 30 : 90);
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !m_acc[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < prob);
          bus.req_data[i*DW +: DW] = 8'($urandom);
          bus.req_last[i] = ($urandom_range(0, 3) == 0);
        end
      end
      bus.fifo_full = ($urandom_range(0, 99) < 20);
      smp();
    end
    total++;
    if (wr_cnt - w0 < 500) begin bad++; $display("FAIL rand_progress writes=%0d want>=500", wr_cnt - w0); end
    nxt();
    bus.req_valid = '0; bus.fifo_full = 1'b0;
  endtask

  initial begin
    wr_cnt = 0;
    test_reset();
    test_single();
    test_rr_all();
    test_full();
    test_timeout();
    test_reset_mid();
    test_prio();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
